// File: rtl/pu_riscv_biu_arbiter_pkg.sv
// Shared types and the grant-selection rule for the BIU arbiter.
// PU_RISCV_BIU_ARB_RR_EN switches tie-breaking from dat-over-ins to round-robin.
package pu_riscv_biu_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_INS  = 2'd1,
    ARB_DAT  = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_INS = 1'b0,
    OWN_DAT = 1'b1
  } arb_owner_t;

`ifdef PU_RISCV_BIU_ARB_RR_EN
  localparam bit ARB_RR_EN = 1'b1;
`else
  localparam bit ARB_RR_EN = 1'b0;
`endif

  // On a tie the side that did not own the port last wins when round-robin is on.
  function automatic arb_state_t arb_pick(input logic ins_req, input logic dat_req,
                                          input arb_owner_t last_owner);
    arb_state_t pick;
    if (ins_req && dat_req)
      pick = (ARB_RR_EN && (last_owner == OWN_DAT)) ? ARB_INS : ARB_DAT;
    else if (dat_req)
      pick = ARB_DAT;
    else if (ins_req)
      pick = ARB_INS;
    else
      pick = ARB_IDLE;
    return pick;
  endfunction

endpackage

// File: rtl/pu_riscv_biu_arbiter_if.sv
// One BIU request/response bundle; master drives the request, slave answers it.
interface pu_riscv_biu_arbiter_if #(
  parameter int XLEN = 64,
  parameter int PLEN = 64
);
  logic            stb;
  logic [PLEN-1:0] adri;
  logic [2:0]      size;
  logic [2:0]      btype;
  logic [2:0]      prot;
  logic            we;
  logic            lock;
  logic [XLEN-1:0] d;
  logic            stb_ack;
  logic            d_ack;
  logic            ack;
  logic            err;
  logic [PLEN-1:0] adro;
  logic [XLEN-1:0] q;

  modport master (
    output stb, adri, size, btype, prot, we, lock, d,
    input  stb_ack, d_ack, ack, err, adro, q
  );

  modport slave (
    input  stb, adri, size, btype, prot, we, lock, d,
    output stb_ack, d_ack, ack, err, adro, q
  );
endinterface

// File: rtl/pu_riscv_biu_arbiter_cnt.sv
// Outstanding-transfer counter: saturates at 0 on stray completions, flags full.
module pu_riscv_biu_arb_cnt #(
  parameter  int MAX_OUTSTANDING = 4,
  localparam int CW              = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  input  logic          dec,
  input  logic          clr,
  output logic [CW-1:0] cnt,
  output logic          full
);

  always_ff @(posedge clk) begin
    if (!rst_n || clr)
      cnt <= '0;
    else if (inc && !dec)
      cnt <= cnt + CW'(1);
    else if (dec && !inc && (cnt != '0))
      cnt <= cnt - CW'(1);
  end

  assign full = (cnt == CW'(MAX_OUTSTANDING));

endmodule

// File: rtl/pu_riscv_biu_arbiter.sv
// Shares one BIU master port between the instruction and data requesters.
// Define PU_RISCV_BIU_ARB_RR_EN for round-robin ties; default is dat-over-ins priority.
//
// state    | meaning
// ARB_IDLE | no owner, forwarded outputs held 0
// ARB_INS  | instruction side owns the master port
// ARB_DAT  | data side owns the master port
module pu_riscv_biu_arbiter
  import pu_riscv_biu_arb_pkg::*;
#(
  parameter int XLEN            = 64,
  parameter int PLEN            = 64,
  parameter int MAX_OUTSTANDING = 4
) (
  input logic                    HCLK,
  input logic                    HRESETn,
  pu_riscv_biu_arbiter_if.slave  ins_biu,
  pu_riscv_biu_arbiter_if.slave  dat_biu,
  pu_riscv_biu_arbiter_if.master biu
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  arb_state_t    state_q, state_d;
  arb_owner_t    last_owner;
  logic [CW-1:0] cnt;
  logic          full;
  logic          own_ins, own_dat;
  logic          owner_stb;
  logic          fwd_stb;
  logic          stb_ack_fwd;
  logic          cnt_inc, cnt_dec, cnt_clr;

  always_ff @(posedge HCLK) begin
    if (!HRESETn)
      state_q <= ARB_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARB_INS:
        if (!(ins_biu.stb || ins_biu.lock || (cnt != '0)))
          state_d = arb_pick(ins_biu.stb, dat_biu.stb, last_owner);
      ARB_DAT:
        if (!(dat_biu.stb || dat_biu.lock || (cnt != '0)))
          state_d = arb_pick(ins_biu.stb, dat_biu.stb, last_owner);
      default:
        state_d = arb_pick(ins_biu.stb, dat_biu.stb, last_owner);
    endcase
  end

`ifdef PU_RISCV_BIU_ARB_RR_EN
  always_ff @(posedge HCLK) begin
    if (!HRESETn)
      last_owner <= OWN_INS;
    else if (state_d == ARB_INS)
      last_owner <= OWN_INS;
    else if (state_d == ARB_DAT)
      last_owner <= OWN_DAT;
  end
`else
  assign last_owner = OWN_INS;
`endif

  // Reset gates ownership directly so outputs are quiet before the first edge too.
  assign own_ins     = HRESETn & (state_q == ARB_INS);
  assign own_dat     = HRESETn & (state_q == ARB_DAT);
  assign owner_stb   = (own_ins & ins_biu.stb) | (own_dat & dat_biu.stb);
  assign fwd_stb     = owner_stb & ~full;
  assign stb_ack_fwd = biu.stb_ack & fwd_stb;

  assign biu.stb = fwd_stb;

  always_comb begin
    biu.adri  = '0;
    biu.size  = '0;
    biu.btype = '0;
    biu.prot  = '0;
    biu.we    = 1'b0;
    biu.lock  = 1'b0;
    biu.d     = '0;
    if (own_ins) begin
      biu.adri  = ins_biu.adri;
      biu.size  = ins_biu.size;
      biu.btype = ins_biu.btype;
      biu.prot  = ins_biu.prot;
      biu.we    = ins_biu.we;
      biu.lock  = ins_biu.lock;
      biu.d     = ins_biu.d;
    end else if (own_dat) begin
      biu.adri  = dat_biu.adri;
      biu.size  = dat_biu.size;
      biu.btype = dat_biu.btype;
      biu.prot  = dat_biu.prot;
      biu.we    = dat_biu.we;
      biu.lock  = dat_biu.lock;
      biu.d     = dat_biu.d;
    end
  end

  assign ins_biu.stb_ack = own_ins & stb_ack_fwd;
  assign ins_biu.d_ack   = own_ins & biu.d_ack;
  assign ins_biu.ack     = own_ins & biu.ack;
  assign ins_biu.err     = own_ins & biu.err;
  assign ins_biu.adro    = own_ins ? biu.adro : '0;
  assign ins_biu.q       = own_ins ? biu.q    : '0;

  assign dat_biu.stb_ack = own_dat & stb_ack_fwd;
  assign dat_biu.d_ack   = own_dat & biu.d_ack;
  assign dat_biu.ack     = own_dat & biu.ack;
  assign dat_biu.err     = own_dat & biu.err;
  assign dat_biu.adro    = own_dat ? biu.adro : '0;
  assign dat_biu.q       = own_dat ? biu.q    : '0;

  // Completions are only counted against a live grant; idle keeps the count at 0.
  assign cnt_inc = stb_ack_fwd;
  assign cnt_dec = biu.ack | biu.err;
  assign cnt_clr = ~(own_ins | own_dat);

  pu_riscv_biu_arb_cnt #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING)
  ) u_cnt (
    .clk   (HCLK),
    .rst_n (HRESETn),
    .inc   (cnt_inc),
    .dec   (cnt_dec),
    .clr   (cnt_clr),
    .cnt   (cnt),
    .full  (full)
  );

endmodule

// File: tb/tb_pu_riscv_biu_arbiter.sv
// Directed scenarios followed by random traffic, all checked against a
// transaction-level owner/outstanding model.
module tb_pu_riscv_biu_arbiter;

  localparam int XLEN = 64;
  localparam int PLEN = 64;
  localparam int MAXO = 4;
  localparam logic [63:0] INS_A = 64'h0000_0000_8000_0000;
  localparam logic [63:0] DAT_A = 64'h0000_0000_0000_1000;

  logic HCLK;
  logic rst_n;

  pu_riscv_biu_arbiter_if #(.XLEN(XLEN), .PLEN(PLEN)) ins_if ();
  pu_riscv_biu_arbiter_if #(.XLEN(XLEN), .PLEN(PLEN)) dat_if ();
  pu_riscv_biu_arbiter_if #(.XLEN(XLEN), .PLEN(PLEN)) biu_if ();

  pu_riscv_biu_arbiter #(.XLEN(XLEN), .PLEN(PLEN), .MAX_OUTSTANDING(MAXO)) dut (
    .HCLK    (HCLK),
    .HRESETn (rst_n),
    .ins_biu (ins_if),
    .dat_biu (dat_if),
    .biu     (biu_if)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  int n_chk  = 0;
  int n_fail = 0;

  // Model: 0 = nobody owns the port, 1 = ins, 2 = dat.
  int m_owner = 0;
  int m_cnt   = 0;
  int m_last  = 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input bit i, input bit d);
    if (i && d) begin
`ifdef PU_RISCV_BIU_ARB_RR_EN
      return (m_last == 2) ? 1 : 2;
`else
      return 2;
`endif
    end
    if (d) return 2;
    if (i) return 1;
    return 0;
  endfunction

  // Compare all outputs at the falling edge, then advance the model across the rising edge.
  task automatic step();
    logic        e_stb;
    logic [63:0] e_adri, e_attr, e_d, e_resp_adro, e_resp_q;
    logic [3:0]  e_hs;
    bit          hold;
    int          nc;
    @(negedge HCLK);
    e_stb = 1'b0; e_adri = '0; e_attr = '0; e_d = '0;
    if (rst_n && m_owner == 1) begin
      e_stb  = ins_if.stb && (m_cnt < MAXO);
      e_adri = ins_if.adri;
      e_attr = 64'({ins_if.size, ins_if.btype, ins_if.prot, ins_if.we, ins_if.lock});
      e_d    = ins_if.d;
    end else if (rst_n && m_owner == 2) begin
      e_stb  = dat_if.stb && (m_cnt < MAXO);
      e_adri = dat_if.adri;
      e_attr = 64'({dat_if.size, dat_if.btype, dat_if.prot, dat_if.we, dat_if.lock});
      e_d    = dat_if.d;
    end
    e_hs        = {e_stb & biu_if.stb_ack, biu_if.d_ack, biu_if.ack, biu_if.err};
    e_resp_adro = biu_if.adro;
    e_resp_q    = biu_if.q;
    chk("fwd_stb",  64'(biu_if.stb), 64'(e_stb));
    chk("fwd_adri", biu_if.adri, e_adri);
    chk("fwd_attr", 64'({biu_if.size, biu_if.btype, biu_if.prot, biu_if.we, biu_if.lock}), e_attr);
    chk("fwd_d",    biu_if.d, e_d);
    chk("ins_hs",   64'({ins_if.stb_ack, ins_if.d_ack, ins_if.ack, ins_if.err}),
        (rst_n && m_owner == 1) ? 64'(e_hs) : 64'd0);
    chk("ins_adro", ins_if.adro, (rst_n && m_owner == 1) ? e_resp_adro : 64'd0);
    chk("ins_q",    ins_if.q,    (rst_n && m_owner == 1) ? e_resp_q    : 64'd0);
    chk("dat_hs",   64'({dat_if.stb_ack, dat_if.d_ack, dat_if.ack, dat_if.err}),
        (rst_n && m_owner == 2) ? 64'(e_hs) : 64'd0);
    chk("dat_adro", dat_if.adro, (rst_n && m_owner == 2) ? e_resp_adro : 64'd0);
    chk("dat_q",    dat_if.q,    (rst_n && m_owner == 2) ? e_resp_q    : 64'd0);
    @(posedge HCLK);
    if (!rst_n) begin
      m_owner = 0; m_cnt = 0; m_last = 1;
    end else begin
      hold = (m_owner == 1) ? (ins_if.stb || ins_if.lock || m_cnt != 0) :
             (m_owner == 2) ? (dat_if.stb || dat_if.lock || m_cnt != 0) : 1'b0;
      nc = 0;
      if (m_owner != 0) begin
        nc = m_cnt + int'(e_stb && biu_if.stb_ack) - int'(biu_if.ack || biu_if.err);
        if (nc < 0) nc = 0;
      end
      if (!hold) m_owner = pick(ins_if.stb, dat_if.stb);
      if (m_owner != 0) m_last = m_owner;
      m_cnt = nc;
    end
    #1;
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    ins_if.stb = 1'b1; ins_if.adri = INS_A; ins_if.size = 3'd3; ins_if.btype = 3'd0;
    ins_if.prot = 3'd4; ins_if.we = 1'b0; ins_if.lock = 1'b0; ins_if.d = 64'h1111_2222_3333_4444;
    dat_if.stb = 1'b1; dat_if.adri = DAT_A; dat_if.size = 3'd2; dat_if.btype = 3'd1;
    dat_if.prot = 3'd1; dat_if.we = 1'b1; dat_if.lock = 1'b0; dat_if.d = 64'hdead_beef_cafe_f00d;
    biu_if.stb_ack = 1'b0; biu_if.d_ack = 1'b0; biu_if.ack = 1'b0; biu_if.err = 1'b0;
    biu_if.adro = 64'h0000_0000_0000_5a5a; biu_if.q = 64'h0123_4567_89ab_cdef;

    // Reset held with both strobes high, then data wins the first tie.
    steps(3);
    chk("rst_stb", 64'(biu_if.stb), 64'd0);
    rst_n = 1'b1;
    step();
    chk("rst_rel_stb",  64'(biu_if.stb), 64'd1);
    chk("rst_rel_adri", biu_if.adri, DAT_A);

    // Data transfer completes, instruction side follows with no bubble.
    biu_if.stb_ack = 1'b1; step();
    biu_if.stb_ack = 1'b0; dat_if.stb = 1'b0; step();
    biu_if.ack = 1'b1; step();
    biu_if.ack = 1'b0; step();
    chk("nobubble_stb",  64'(biu_if.stb), 64'd1);
    chk("nobubble_adri", biu_if.adri, INS_A);
    biu_if.stb_ack = 1'b1; step();
    biu_if.stb_ack = 1'b0; ins_if.stb = 1'b0; biu_if.ack = 1'b1; step();
    biu_if.ack = 1'b0; step();
    chk("idle_after_ins", 64'(biu_if.stb), 64'd0);

    // Pipelined data reads fill the outstanding window.
    dat_if.stb = 1'b1; dat_if.we = 1'b0; biu_if.stb_ack = 1'b1;
    steps(5);
    chk("full_cnt",     64'(dut.u_cnt.cnt), 64'd4);
    chk("full_stb",     64'(biu_if.stb), 64'd0);
    chk("full_stb_ack", 64'(dat_if.stb_ack), 64'd0);
    steps(2);
    chk("full_hold_stb", 64'(biu_if.stb), 64'd0);
    biu_if.ack = 1'b1; step();
    biu_if.ack = 1'b0;
    #1;
    chk("refill_stb", 64'(biu_if.stb), 64'd1);
    step();
    dat_if.stb = 1'b0; biu_if.stb_ack = 1'b0; biu_if.ack = 1'b1;
    steps(4);
    chk("drain_cnt",  64'(dut.u_cnt.cnt), 64'd0);
    chk("drain_owner", biu_if.adri, DAT_A);
    biu_if.ack = 1'b0; step();

    // Locked data sequence stalls the instruction side.
    dat_if.stb = 1'b1; dat_if.lock = 1'b1; ins_if.stb = 1'b1;
    step();
    for (int i = 0; i < 6; i++) begin
      dat_if.stb = i[0];
      step();
      chk("lock_keep", biu_if.adri, DAT_A);
    end
    dat_if.stb = 1'b0; dat_if.lock = 1'b0;
    step();
    chk("lock_release", biu_if.adri, INS_A);
    ins_if.stb = 1'b0; step();

    // Error on the middle of three data transfers.
    dat_if.stb = 1'b1; ins_if.stb = 1'b1; biu_if.stb_ack = 1'b1;
    steps(4);
    chk("err_cnt3", 64'(dut.u_cnt.cnt), 64'd3);
    dat_if.stb = 1'b0; biu_if.stb_ack = 1'b0; biu_if.ack = 1'b1; step();
    biu_if.ack = 1'b0; biu_if.err = 1'b1;
    #1;
    chk("err_dat", 64'(dat_if.err), 64'd1);
    chk("err_ins", 64'(ins_if.err), 64'd0);
    step();
    chk("err_cnt1", 64'(dut.u_cnt.cnt), 64'd1);
    biu_if.err = 1'b0; biu_if.ack = 1'b1; step();
    chk("err_cnt0", 64'(dut.u_cnt.cnt), 64'd0);
    biu_if.ack = 1'b0; step();
    ins_if.stb = 1'b0; step();

    // Reset in the middle of a burst.
    dat_if.stb = 1'b1; biu_if.stb_ack = 1'b1;
    steps(3);
    chk("mid_cnt2", 64'(dut.u_cnt.cnt), 64'd2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_stb", 64'(biu_if.stb), 64'd0);
    step();
    chk("mid_rst_cnt", 64'(dut.u_cnt.cnt), 64'd0);
    rst_n = 1'b1; dat_if.stb = 1'b0; biu_if.stb_ack = 1'b0; biu_if.ack = 1'b1;
    #1;
    chk("mid_rst_noack", 64'(dat_if.ack), 64'd0);
    steps(2);
    biu_if.ack = 1'b0;

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      rst_n          = ($urandom_range(63) != 0);
      ins_if.stb     = $urandom_range(1);
      dat_if.stb     = $urandom_range(1);
      ins_if.lock    = ($urandom_range(7) == 0);
      dat_if.lock    = ($urandom_range(7) == 0);
      ins_if.adri    = {$urandom, $urandom};
      dat_if.adri    = {$urandom, $urandom};
      ins_if.d       = {$urandom, $urandom};
      dat_if.d       = {$urandom, $urandom};
      ins_if.size    = 3'($urandom); ins_if.btype = 3'($urandom); ins_if.prot = 3'($urandom);
      dat_if.size    = 3'($urandom); dat_if.btype = 3'($urandom); dat_if.prot = 3'($urandom);
      ins_if.we      = $urandom_range(1);
      dat_if.we      = $urandom_range(1);
      biu_if.stb_ack = ($urandom_range(2) == 0);
      biu_if.d_ack   = ($urandom_range(2) == 0);
      biu_if.ack     = ($urandom_range(2) == 0);
      biu_if.err     = ($urandom_range(7) == 0);
      biu_if.adro    = {$urandom, $urandom};
      biu_if.q       = {$urandom, $urandom};
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
